// File: rtl/score_keeper.sv
// Game score keeper: BCD score with saturation, level progression and
// best-score/best-level tracking across games until reset.
//
// state | meaning
// IDLE  | after reset, waiting for new_game; inputs ignored
// RUN   | game active; point/bonus add score, collision ends game
// OVER  | game ended; score/level frozen until new_game
module score_keeper #(
    parameter int LEVEL_STEP = 20,
    parameter int MAX_LEVEL  = 7
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        new_game,
    input  logic        point,
    input  logic        bonus,
    input  logic        collision,
    output logic [11:0] score,
    output logic [2:0]  level,
    output logic [11:0] high_score,
    output logic [2:0]  high_level,
    output logic        game_over,
    output logic        level_up
);

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    state_t      state_q, state_d;
    logic [11:0] score_q, score_d;
    logic [2:0]  level_q, level_d;
    logic [6:0]  prog_q, prog_d;
    logic [11:0] hi_score_q, hi_score_d;
    logic [2:0]  hi_level_q, hi_level_d;
    logic        level_up_q, level_up_d;

    logic [2:0]  add;
    logic [4:0]  sum0, sum1, sum2;
    logic        c0, c1, c2;
    logic [3:0]  dig0, dig1, dig2;
    logic [11:0] score_sum;
    logic [6:0]  prog_sum;

    // Per-digit decimal add; a carry out of the hundreds digit means > 999.
    always_comb begin
        add  = {2'b00, point} + (bonus ? 3'd5 : 3'd0);
        sum0 = {1'b0, score_q[3:0]} + {2'b00, add};
        c0   = (sum0 > 5'd9);
        dig0 = c0 ? 4'(sum0 - 5'd10) : sum0[3:0];
        sum1 = {1'b0, score_q[7:4]} + {4'b0000, c0};
        c1   = (sum1 > 5'd9);
        dig1 = c1 ? 4'(sum1 - 5'd10) : sum1[3:0];
        sum2 = {1'b0, score_q[11:8]} + {4'b0000, c1};
        c2   = (sum2 > 5'd9);
        dig2 = c2 ? 4'(sum2 - 5'd10) : sum2[3:0];
        score_sum = c2 ? 12'h999 : {dig2, dig1, dig0};
        prog_sum  = prog_q + {4'b0000, add};
    end

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        level_d    = level_q;
        prog_d     = prog_q;
        level_up_d = 1'b0;
        hi_score_d = (score_q > hi_score_q) ? score_q : hi_score_q;
        hi_level_d = (level_q > hi_level_q) ? level_q : hi_level_q;

        if (new_game) begin
            state_d = RUN;
            score_d = 12'h000;
            level_d = 3'd1;
            prog_d  = 7'd0;
        end else if (state_q == RUN) begin
            if (collision) begin
                state_d = OVER;
            end else begin
                score_d = score_sum;
                if (level_q < 3'(MAX_LEVEL)) begin
                    if (prog_sum >= 7'(LEVEL_STEP)) begin
                        level_d    = level_q + 3'd1;
                        level_up_d = 1'b1;
                        // Progress is parked at 0 once the ceiling is reached.
                        prog_d     = (level_q == 3'(MAX_LEVEL - 1)) ?
                                     7'd0 : prog_sum - 7'(LEVEL_STEP);
                    end else begin
                        prog_d = prog_sum;
                    end
                end else begin
                    prog_d = 7'd0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            score_q    <= 12'h000;
            level_q    <= 3'd0;
            prog_q     <= 7'd0;
            hi_score_q <= 12'h000;
            hi_level_q <= 3'd0;
            level_up_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            level_q    <= level_d;
            prog_q     <= prog_d;
            hi_score_q <= hi_score_d;
            hi_level_q <= hi_level_d;
            level_up_q <= level_up_d;
        end
    end

    assign score      = score_q;
    assign level      = level_q;
    assign high_score = hi_score_q;
    assign high_level = hi_level_q;
    assign game_over  = (state_q == OVER);
    assign level_up   = level_up_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper with default parameters
// (LEVEL_STEP=20, MAX_LEVEL=7).
module tb_score_keeper;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        new_game = 1'b0;
    logic        point = 1'b0;
    logic        bonus = 1'b0;
    logic        collision = 1'b0;
    logic [11:0] score;
    logic [2:0]  level;
    logic [11:0] high_score;
    logic [2:0]  high_level;
    logic        game_over;
    logic        level_up;

    int n_cmp = 0;
    int n_err = 0;

    score_keeper #(.LEVEL_STEP(20), .MAX_LEVEL(7)) dut (
        .clock(clock), .resetn(resetn), .new_game(new_game), .point(point),
        .bonus(bonus), .collision(collision), .score(score), .level(level),
        .high_score(high_score), .high_level(high_level),
        .game_over(game_over), .level_up(level_up)
    );

    always #5 clock = ~clock;

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic pulse(input logic p, input logic b, input logic c, input logic g);
        point = p; bonus = b; collision = c; new_game = g;
        @(posedge clock); #1;
        point = 0; bonus = 0; collision = 0; new_game = 0;
    endtask

    task automatic test_reset();
        resetn = 0;
        repeat (2) @(posedge clock);
        @(negedge clock); resetn = 1;
        @(posedge clock); #1;
        n_cmp++; if ({score, level, high_score, high_level, game_over, level_up} !== 32'd0) begin
            n_err++; $display("FAIL reset_outputs: got %h/%0d/%h/%0d/%b/%b required all 0",
                              score, level, high_score, high_level, game_over, level_up);
        end
        pulse(1, 1, 0, 0);
        n_cmp++; if (score !== 12'h000 || level !== 3'd0) begin
            n_err++; $display("FAIL idle_ignore: score %h level %0d required 000/0", score, level);
        end
    endtask

    task automatic test_points();
        pulse(0, 0, 0, 1);
        n_cmp++; if (score !== 12'h000 || level !== 3'd1 || game_over !== 1'b0) begin
            n_err++; $display("FAIL new_game_start: score %h level %0d go %b required 000/1/0", score, level, game_over);
        end
        for (int i = 0; i < 12; i++) pulse(1, 0, 0, 0);
        n_cmp++; if (score !== 12'h012 || level !== 3'd1) begin
            n_err++; $display("FAIL twelve_points: score %h level %0d required 012/1", score, level);
        end
        pulse(0, 0, 0, 0);
        n_cmp++; if (high_score !== 12'h012 || high_level !== 3'd1) begin
            n_err++; $display("FAIL high_after_points: high %h hl %0d required 012/1", high_score, high_level);
        end
    endtask

    task automatic test_collision();
        pulse(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        pulse(1, 0, 0, 0);
        n_cmp++; if (score !== 12'h042 || level !== 3'd3) begin
            n_err++; $display("FAIL score_42: score %h level %0d required 042/3", score, level);
        end
        pulse(1, 0, 1, 0);
        n_cmp++; if (game_over !== 1'b1 || score !== 12'h042) begin
            n_err++; $display("FAIL collision_point: go %b score %h required 1/042", game_over, score);
        end
        for (int i = 0; i < 3; i++) pulse(1, 1, 0, 0);
        n_cmp++; if (score !== 12'h042 || level !== 3'd3 || game_over !== 1'b1) begin
            n_err++; $display("FAIL over_ignore: score %h level %0d go %b required 042/3/1", score, level, game_over);
        end
        pulse(0, 0, 0, 1);
        n_cmp++; if (score !== 12'h000 || level !== 3'd1 || game_over !== 1'b0 ||
                     high_score !== 12'h042 || high_level !== 3'd3) begin
            n_err++; $display("FAIL restart_keeps_high: score %h lvl %0d go %b high %h hl %0d required 000/1/0/042/3",
                              score, level, game_over, high_score, high_level);
        end
    endtask

    task automatic test_carry();
        pulse(0, 0, 0, 1);
        for (int i = 0; i < 19; i++) pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        pulse(1, 0, 0, 0);
        n_cmp++; if (score !== 12'h097) begin
            n_err++; $display("FAIL score_97: score %h required 097", score);
        end
        pulse(1, 1, 0, 0);
        n_cmp++; if (score !== 12'h103 || level !== 3'd6) begin
            n_err++; $display("FAIL carry_103: score %h level %0d required 103/6", score, level);
        end
    endtask

    task automatic test_level();
        int ups;
        int bad;
        pulse(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) pulse(0, 1, 0, 0);
        n_cmp++; if (level !== 3'd1 || level_up !== 1'b0) begin
            n_err++; $display("FAIL level_15pts: level %0d up %b required 1/0", level, level_up);
        end
        pulse(0, 1, 0, 0);
        n_cmp++; if (level !== 3'd2 || level_up !== 1'b1) begin
            n_err++; $display("FAIL level_20pts: level %0d up %b required 2/1", level, level_up);
        end
        pulse(0, 0, 0, 0);
        n_cmp++; if (level !== 3'd2 || level_up !== 1'b0) begin
            n_err++; $display("FAIL level_up_single: level %0d up %b required 2/0", level, level_up);
        end
        ups = 0; bad = 0;
        for (int i = 0; i < 20; i++) begin
            pulse(0, 1, 0, 0);
            if (level_up) ups++;
            if (level_up !== ((i % 4) == 3)) bad++;
        end
        n_cmp++; if (ups !== 5 || bad !== 0 || level !== 3'd7) begin
            n_err++; $display("FAIL level_to_max: pulses %0d misplaced %0d level %0d required 5/0/7", ups, bad, level);
        end
        ups = 0;
        for (int i = 0; i < 25; i++) begin
            pulse(1, 0, 0, 0);
            if (level_up !== 1'b0) ups++;
        end
        n_cmp++; if (ups !== 0 || level !== 3'd7) begin
            n_err++; $display("FAIL level_hold_max: pulses %0d level %0d required 0/7", ups, level);
        end
    endtask

    task automatic test_saturate();
        pulse(0, 0, 0, 1);
        for (int i = 0; i < 199; i++) pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        n_cmp++; if (score !== 12'h996 || level !== 3'd7) begin
            n_err++; $display("FAIL score_996: score %h level %0d required 996/7", score, level);
        end
        pulse(0, 1, 0, 0);
        n_cmp++; if (score !== 12'h999) begin
            n_err++; $display("FAIL saturate_bonus: score %h required 999", score);
        end
        pulse(1, 0, 0, 0);
        n_cmp++; if (score !== 12'h999 || level_up !== 1'b0) begin
            n_err++; $display("FAIL saturate_point: score %h up %b required 999/0", score, level_up);
        end
        pulse(0, 0, 0, 0);
        n_cmp++; if (high_score !== 12'h999 || high_level !== 3'd7) begin
            n_err++; $display("FAIL high_999: high %h hl %0d required 999/7", high_score, high_level);
        end
    endtask

    task automatic test_async_reset();
        pulse(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) pulse(1, 0, 0, 0);
        #2 resetn = 0;
        #1;
        n_cmp++; if ({score, level, high_score, high_level, game_over, level_up} !== 32'd0) begin
            n_err++; $display("FAIL async_reset: got %h/%0d/%h/%0d/%b/%b required all 0",
                              score, level, high_score, high_level, game_over, level_up);
        end
        @(negedge clock); resetn = 1;
        pulse(0, 0, 0, 1);
        pulse(1, 0, 0, 0);
        n_cmp++; if (score !== 12'h001 || level !== 3'd1 || game_over !== 1'b0) begin
            n_err++; $display("FAIL post_reset_game: score %h level %0d go %b required 001/1/0", score, level, game_over);
        end
    endtask

    initial begin
        test_reset();
        test_points();
        test_collision();
        test_carry();
        test_level();
        test_saturate();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
